elevator_request_latch: RTL and testbench

Front-end request stage for the `elevator` controller. It takes raw, asynchronous, bouncy floor buttons, then synchronises and debounces each one. Each debounced press is held as a pending request until the controller reports that it has served that floor. Its `requests` output drives the controller's `buttons` input directly, so the controller sees clean, level-held requests.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/button_debounce.sv | 129 ++++++++++++
 rtl/elevator_request_latch.sv | 75 +++++++
 tb/tb_elevator_request_latch.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator request front end.
//   NUM_FLOORS_DEF : default number of floors / buttons
//   FLOOR_W_DEF    : width of a floor index for the default floor count
//   db_state_t     : per-button debouncer state
// ---------------------------------------------------------------------------
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 5;
  localparam int FLOOR_W_DEF    = $clog2(NUM_FLOORS_DEF);

  typedef enum logic [1:0] {
    LOW      = 2'd0,  // settled released
    CHK_HIGH = 2'd1,  // released, counting pressed samples
    HIGH     = 2'd2,  // settled pressed
    CHK_LOW  = 2'd3   // pressed, counting released samples
  } db_state_t;

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Synchronises one raw, asynchronous button level and debounces it.
// A level change is accepted after DEBOUNCE_CYCLES consecutive matching
// synchronised samples.
// Ports:
//   clk    : system clock (rising edge)
//   rst_n  : asynchronous active-low reset
//   raw    : raw button level, 1 = pressed
//   stable : debounced level (high in HIGH and CHK_LOW)
//   rise   : high during the cycle whose closing edge enters HIGH from the
//            released side; the parent latches a press on that edge
// ---------------------------------------------------------------------------
module button_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             s1;
  logic             s2;
  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_inc_sat;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter holds the number of matching samples seen so far,
  // including the one that caused entry to a CHK state.
  always_comb begin
    cnt_inc_sat = (cnt == CNT_MAX) ? 1'b0 : 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      LOW: begin
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = HIGH;
            cnt_next   = '0;
          end else begin
            state_next = CHK_HIGH;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      CHK_HIGH: begin
        if (!s2) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt_inc_sat) begin
          cnt_next = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = LOW;
            cnt_next   = '0;
          end else begin
            state_next = CHK_LOW;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      CHK_LOW: begin
        if (s2) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt_inc_sat) begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs. A return from CHK_LOW to HIGH is a bounce on a held button,
  // not a new press, so only entries from the released side count.
  always_comb begin
    stable = (state == HIGH) || (state == CHK_LOW);
    rise   = (state_next == HIGH) && ((state == LOW) || (state == CHK_HIGH));
  end

endmodule

// File: rtl/elevator_request_latch.sv
// ---------------------------------------------------------------------------
// elevator_request_latch
// Debounces every floor button and holds each accepted press as a pending
// request until the controller serves that floor.
// Ports:
//   clk         : system clock (rising edge)
//   rst_n       : asynchronous active-low reset
//   buttons_raw : raw button levels, 1 = pressed
//   serve_valid : controller served serve_floor this cycle
//   serve_floor : served floor index; out-of-range values are ignored
//   requests    : pending request per floor
//   press_pulse : one-cycle pulse per accepted press
//   any_request : OR of requests
// ---------------------------------------------------------------------------
module elevator_request_latch
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_DEF,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FLOOR_W         = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] buttons_raw,
  input  logic                  serve_valid,
  input  logic [FLOOR_W-1:0]    serve_floor,
  output logic [NUM_FLOORS-1:0] requests,
  output logic [NUM_FLOORS-1:0] press_pulse,
  output logic                  any_request
);

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] stable;
  logic [NUM_FLOORS-1:0] press_now;
  logic [NUM_FLOORS-1:0] serve_hit;
  logic [NUM_FLOORS-1:0] requests_next;

  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (buttons_raw[gi]),
        .stable (stable[gi]),
        .rise   (rise[gi])
      );

      // A press can only be accepted from the released side.
      assign press_now[gi] = rise[gi] & ~stable[gi];

      // Out-of-range floor indices never match any decoder output.
      assign serve_hit[gi] = serve_valid && (serve_floor == FLOOR_W'(gi));
    end
  endgenerate

  // Clear has priority over a same-edge press on the same floor.
  always_comb begin
    requests_next = (requests | press_now) & ~serve_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      requests    <= '0;
      press_pulse <= '0;
    end else begin
      requests    <= requests_next;
      press_pulse <= press_now;
    end
  end

  assign any_request = |requests;

endmodule

// File: tb/tb_elevator_request_latch.sv
// ---------------------------------------------------------------------------
// tb_elevator_request_latch
// Directed scenarios followed by randomized button/serve traffic. A
// sample-history reference model predicts requests, press_pulse and
// any_request; outputs are compared on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_elevator_request_latch;

  localparam int NF = 5;
  localparam int D  = 4;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] buttons_raw = '0;
  logic          serve_valid = 1'b0;
  logic [FW-1:0] serve_floor = '0;
  logic [NF-1:0] requests;
  logic [NF-1:0] press_pulse;
  logic          any_request;

  always #5 clk = ~clk;

  elevator_request_latch #(
    .NUM_FLOORS      (NF),
    .DEBOUNCE_CYCLES (D),
    .FLOOR_W         (FW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .buttons_raw (buttons_raw),
    .serve_valid (serve_valid),
    .serve_floor (serve_floor),
    .requests    (requests),
    .press_pulse (press_pulse),
    .any_request (any_request)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw is seen two edges late; the accepted level flips
  // once the run of identical delayed samples that differs from it reaches D.
  bit            m_s1   [NF];
  bit            m_s2   [NF];
  bit            m_last [NF];
  bit            m_stab [NF];
  int            m_run  [NF];
  logic [NF-1:0] m_req;
  logic [NF-1:0] m_pulse;

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_s1[i]   = 1'b0;
      m_s2[i]   = 1'b0;
      m_last[i] = 1'b0;
      m_stab[i] = 1'b0;
      m_run[i]  = 0;
    end
    m_req   = '0;
    m_pulse = '0;
  endtask

  task automatic model_step();
    logic [NF-1:0] press;
    bit            s;
    press = '0;
    for (int i = 0; i < NF; i++) begin
      s = m_s2[i];
      if (s == m_last[i]) begin
        if (m_run[i] < D) m_run[i] = m_run[i] + 1;
      end else begin
        m_run[i] = 1;
      end
      m_last[i] = s;
      if (s != m_stab[i] && m_run[i] >= D) begin
        m_stab[i] = s;
        if (s) press[i] = 1'b1;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = buttons_raw[i];
    end
    m_pulse = press;
    m_req   = m_req | press;
    if (serve_valid && serve_floor < FW'(NF)) m_req[serve_floor] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every active edge outside reset.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  // Continuous comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_requests", 32'(requests), 32'(m_req));
      chk("cyc_press_pulse", 32'(press_pulse), 32'(m_pulse));
      chk("cyc_any_request", 32'(any_request), 32'(|m_req));
    end
  end

  // Advance n active edges, then settle 2 time units past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    model_reset();
    tick(2);
    chk("reset_requests", 32'(requests), 32'h0);
    chk("reset_any", 32'(any_request), 32'h0);
    rst_n = 1'b1;
    $display("txn: reset released");

    // Clean press on floor 1.
    buttons_raw = 5'b00010;
    tick(5);
    chk("press_not_yet_E4", 32'(requests), 32'h00);
    tick(1);
    chk("press_req_E5", 32'(requests), 32'h02);
    chk("press_pulse_E5", 32'(press_pulse), 32'h02);
    chk("press_any_E5", 32'(any_request), 32'h1);
    tick(1);
    chk("press_pulse_one_cycle", 32'(press_pulse), 32'h00);
    $display("txn: clean press floor 1 requests=%b", requests);
    buttons_raw = '0;
    tick(8);

    // Bounce on floor 3.
    for (int k = 0; k < 4; k++) begin
      buttons_raw[3] = (k % 2 == 0);
      tick(1);
    end
    buttons_raw[3] = 1'b0;
    tick(10);
    chk("bounce_rejected", 32'(requests), 32'h02);
    $display("txn: bounce floor 3 requests=%b", requests);

    // Floor 4 press, then serve 4 and an out-of-range serve.
    buttons_raw[4] = 1'b1;
    tick(6);
    chk("press_floor4", 32'(requests), 32'h12);
    buttons_raw = '0;
    tick(8);
    serve_valid = 1'b1;
    serve_floor = 3'd4;
    tick(1);
    chk("serve_clear4", 32'(requests), 32'h02);
    serve_floor = 3'd6;
    tick(1);
    chk("serve_out_of_range", 32'(requests), 32'h02);
    serve_valid = 1'b0;
    $display("txn: serve 4 then 6 requests=%b", requests);

    // Same-floor collision on floor 0.
    buttons_raw[0] = 1'b1;
    tick(5);
    serve_valid = 1'b1;
    serve_floor = 3'd0;
    tick(1);
    chk("collision_req", 32'(requests), 32'h02);
    chk("collision_pulse", 32'(press_pulse), 32'h01);
    serve_valid = 1'b0;
    tick(1);
    chk("collision_pulse_end", 32'(press_pulse), 32'h00);
    buttons_raw[0] = 1'b0;
    tick(8);
    buttons_raw[0] = 1'b1;
    tick(6);
    chk("repress_floor0", 32'(requests), 32'h03);
    buttons_raw[0] = 1'b0;
    tick(8);
    $display("txn: collision floor 0 requests=%b", requests);

    // Held button on floor 2, served midway.
    buttons_raw[2] = 1'b1;
    tick(6);
    chk("held_latched", 32'(requests), 32'h07);
    tick(44);
    serve_valid = 1'b1;
    serve_floor = 3'd2;
    tick(1);
    serve_valid = 1'b0;
    chk("held_served", 32'(requests), 32'h03);
    tick(50);
    chk("held_no_retrigger", 32'(requests), 32'h03);
    buttons_raw[2] = 1'b0;
    tick(8);
    $display("txn: held floor 2 requests=%b", requests);

    // Reset while floor 4 is mid-debounce.
    buttons_raw[4] = 1'b1;
    tick(4);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_req_immediate", 32'(requests), 32'h0);
    chk("rst_pulse_immediate", 32'(press_pulse), 32'h0);
    chk("rst_any_immediate", 32'(any_request), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_not_yet", 32'(requests), 32'h00);
    tick(1);
    chk("post_rst_held_latch", 32'(requests), 32'h10);
    buttons_raw = '0;
    tick(8);
    $display("txn: reset mid-debounce requests=%b", requests);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NF; i++) begin
        if ($urandom_range(0, 15) == 0) buttons_raw[i] = ~buttons_raw[i];
      end
      serve_valid = ($urandom_range(0, 3) == 0);
      serve_floor = FW'($urandom_range(0, 7));
      tick(1);
      if (c % 250 == 0)
        $display("txn: random cycle %0d requests=%b pulse=%b", c, requests, press_pulse);
    end
    buttons_raw = '0;
    serve_valid = 1'b0;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
